// File: rtl/bg_collision_arbiter_if.sv
// Bus between the background ROM arbiter and its clients: the VGA draw path,
// the background ROM itself and the player-movement collision probe.
interface bg_collision_arbiter_if;
  // VGA draw path
  logic        draw_req;
  logic [17:0] draw_addr;
  logic        draw_valid;
  // Background ROM read port
  logic [17:0] rom_addr;
  logic [3:0]  rom_q;
  // Collision probe
  logic        probe_start;
  logic [8:0]  probe_x;
  logic [8:0]  probe_y;
  logic        probe_busy;
  logic        probe_done;
  logic        probe_blocked;

  // Arbiter side
  modport slave (
    input  draw_req,
    input  draw_addr,
    output draw_valid,
    output rom_addr,
    input  rom_q,
    input  probe_start,
    input  probe_x,
    input  probe_y,
    output probe_busy,
    output probe_done,
    output probe_blocked
  );

  // Environment side: VGA path, ROM and movement logic
  modport master (
    output draw_req,
    output draw_addr,
    input  draw_valid,
    input  rom_addr,
    output rom_q,
    output probe_start,
    output probe_x,
    output probe_y,
    input  probe_busy,
    input  probe_done,
    input  probe_blocked
  );
endinterface

// File: rtl/bg_collision_arbiter.sv
// Shares the single background ROM read port between the VGA draw path (always
// wins) and a four-corner sprite-box collision probe that only uses idle cycles.
module bg_collision_arbiter #(
  parameter int unsigned BG_WIDTH   = 500,
  parameter int unsigned BG_HEIGHT  = 500,
  parameter int unsigned SPRITE_W   = 32,
  parameter int unsigned SPRITE_H   = 32,
  parameter logic [3:0]  WALL_INDEX = 4'd0
) (
  input logic                    clock,
  input logic                    reset,
  bg_collision_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [8:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  // Corner issue index; bit 2 set means all four corners have been handled.
  logic [2:0]  idx_q, idx_d;
  // Corner results collected so far (ROM returns plus out-of-range retirements).
  logic [2:0]  cnt_q, cnt_d;
  logic        acc_q, acc_d;
  // A probe read was issued last cycle, so rom_q carries corner data now.
  logic        tag_q, tag_d;
  logic        draw_valid_q, draw_valid_d;
  logic        blocked_q, blocked_d;

  logic [9:0]  corner_x;
  logic [9:0]  corner_y;
  logic        corner_oob;
  logic [17:0] corner_addr;

  logic        pending;
  logic        issue;
  logic        oob_retire;

  // Current corner coordinates, range check and ROM address.
  always_comb begin
    corner_x = {1'b0, x_q};
    corner_y = {1'b0, y_q};
    if (idx_q[0]) begin
      corner_x = {1'b0, x_q} + 10'(SPRITE_W - 1);
    end
    if (idx_q[1]) begin
      corner_y = {1'b0, y_q} + 10'(SPRITE_H - 1);
    end
    corner_oob  = (corner_x >= 10'(BG_WIDTH)) || (corner_y >= 10'(BG_HEIGHT));
    // Only meaningful for in-range corners, where it never exceeds 18 bits.
    corner_addr = 18'(corner_y) * 18'(BG_WIDTH) + 18'(corner_x);
  end

  // Arbitration and probe FSM next-state.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    tag_d        = 1'b0;
    blocked_d    = blocked_q;
    draw_valid_d = bus.draw_req;
    bus.rom_addr = bus.draw_addr;

    pending    = (state_q == StRun) && !idx_q[2];
    oob_retire = pending && corner_oob;
    issue      = pending && !corner_oob && !bus.draw_req;

    case (state_q)
      StIdle: begin
        if (bus.probe_start) begin
          x_d     = bus.probe_x;
          y_d     = bus.probe_y;
          idx_d   = 3'd0;
          cnt_d   = 3'd0;
          acc_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // An out-of-range corner retires immediately, even under draw contention.
        if (oob_retire) begin
          idx_d = idx_q + 3'd1;
          acc_d = 1'b1;
        end
        if (issue) begin
          bus.rom_addr = corner_addr;
          idx_d        = idx_q + 3'd1;
          tag_d        = 1'b1;
        end
        if (tag_q && (bus.rom_q == WALL_INDEX)) begin
          acc_d = 1'b1;
        end
        // A retirement and a return of an earlier corner can land together.
        cnt_d = cnt_q + {2'b00, oob_retire} + {2'b00, tag_q};
        if (cnt_d == 3'd4) begin
          state_d = StDone;
        end
      end
      StDone: begin
        blocked_d = acc_q;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight return.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      tag_q        <= 1'b0;
      draw_valid_q <= 1'b0;
      blocked_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      tag_q        <= tag_d;
      draw_valid_q <= draw_valid_d;
      blocked_q    <= blocked_d;
    end
  end

  // Outputs; the result is shown from the accumulator during DONE, then held.
  always_comb begin
    bus.draw_valid    = draw_valid_q;
    bus.probe_busy    = (state_q != StIdle);
    bus.probe_done    = (state_q == StDone);
    bus.probe_blocked = (state_q == StDone) ? acc_q : blocked_q;
  end

endmodule

// File: tb/tb_bg_collision_arbiter.sv
// Directed, table-driven bench for bg_collision_arbiter with a behavioural
// background ROM (1-cycle registered read).
module tb_bg_collision_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bg_collision_arbiter_if bus ();

  bg_collision_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] rom_mem [0:262143];
  always @(posedge clock) bus.rom_q <= rom_mem[bus.rom_addr];

  typedef struct {
    logic        rst;
    logic        req;
    logic [17:0] daddr;
    logic        start;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        chk_addr;
    logic [17:0] e_addr;
    logic        e_dv;
    logic        e_busy;
    logic        e_done;
    logic        e_blk;
  } vec_t;

  vec_t  vq[$];
  int    checks = 0;
  int    errors = 0;
  string tname;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus and expected outputs; e_addr < 0 skips the address check.
  task automatic push(input logic rst, input logic req, input logic [17:0] daddr,
                      input logic start, input logic [8:0] x, input logic [8:0] y,
                      input int e_addr, input logic dv, input logic busy,
                      input logic done, input logic blk);
    vec_t v;
    v.rst      = rst;
    v.req      = req;
    v.daddr    = daddr;
    v.start    = start;
    v.x        = x;
    v.y        = y;
    v.chk_addr = (e_addr >= 0);
    v.e_addr   = 18'(e_addr);
    v.e_dv     = dv;
    v.e_busy   = busy;
    v.e_done   = done;
    v.e_blk    = blk;
    vq.push_back(v);
  endtask

  // Idle cycle with draw_addr 5 and no draw request.
  task automatic push_idle(input int e_addr, input logic busy, input logic done,
                           input logic blk);
    push(1'b0, 1'b0, 18'd5, 1'b0, 9'd0, 9'd0, e_addr, 1'b0, busy, done, blk);
  endtask

  // Drive each vector after the falling edge and check outputs 1 time unit later.
  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      reset           = vq[i].rst;
      bus.draw_req    = vq[i].req;
      bus.draw_addr   = vq[i].daddr;
      bus.probe_start = vq[i].start;
      bus.probe_x     = vq[i].x;
      bus.probe_y     = vq[i].y;
      #1;
      if (vq[i].chk_addr) begin
        chk($sformatf("%s[%0d].rom_addr", tname, i), 32'(bus.rom_addr), 32'(vq[i].e_addr));
      end
      chk($sformatf("%s[%0d].draw_valid", tname, i), 32'(bus.draw_valid), 32'(vq[i].e_dv));
      chk($sformatf("%s[%0d].probe_busy", tname, i), 32'(bus.probe_busy), 32'(vq[i].e_busy));
      chk($sformatf("%s[%0d].probe_done", tname, i), 32'(bus.probe_done), 32'(vq[i].e_done));
      chk($sformatf("%s[%0d].probe_blocked", tname, i), 32'(bus.probe_blocked),
          32'(vq[i].e_blk));
    end
    vq.delete();
  endtask

  // Uncontended probe: issues N+1..N+4, done at N+6, idle again at N+7.
  task automatic push_probe(input logic [8:0] x, input logic [8:0] y, input int a0,
                            input int a1, input int a2, input int a3,
                            input logic blk_before, input logic blk_after);
    push(1'b0, 1'b0, 18'd5, 1'b1, x, y, 5, 1'b0, 1'b0, 1'b0, blk_before);
    push_idle(a0, 1'b1, 1'b0, blk_before);
    push_idle(a1, 1'b1, 1'b0, blk_before);
    push_idle(a2, 1'b1, 1'b0, blk_before);
    push_idle(a3, 1'b1, 1'b0, blk_before);
    push_idle(5, 1'b1, 1'b0, blk_before);
    push_idle(5, 1'b1, 1'b1, blk_after);
    push_idle(5, 1'b0, 1'b0, blk_after);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) rom_mem[i] = 4'd3;
    reset           = 1'b1;
    bus.draw_req    = 1'b0;
    bus.draw_addr   = 18'd5;
    bus.probe_start = 1'b0;
    bus.probe_x     = 9'd0;
    bus.probe_y     = 9'd0;
    repeat (2) @(negedge clock);

    tname = "reset";
    push(1'b1, 1'b0, 18'd5, 1'b0, 9'd0, 9'd0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    push_idle(5, 1'b0, 1'b0, 1'b0);
    run_vecs();

    tname = "draw";
    push(1'b0, 1'b1, 18'd123, 1'b0, 9'd0, 9'd0, 123, 1'b0, 1'b0, 1'b0, 1'b0);
    push_idle(5, 1'b0, 1'b0, 1'b0);
    vq[$].e_dv = 1'b1;
    push_idle(5, 1'b0, 1'b0, 1'b0);
    run_vecs();

    tname = "uncontended";
    push_probe(9'd100, 9'd100, 50100, 50131, 65600, 65631, 1'b0, 1'b0);
    run_vecs();

    tname = "wall_hit";
    rom_mem[65631] = 4'd0;
    push_probe(9'd100, 9'd100, 50100, 50131, 65600, 65631, 1'b0, 1'b1);
    run_vecs();

    // Draw owns the ROM N+1..N+3; probe data never raises draw_valid.
    tname = "contention";
    push(1'b0, 1'b0, 18'd5, 1'b1, 9'd100, 9'd100, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 18'd7, 1'b0, 9'd0, 9'd0, 7, 1'b0, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b1, 18'd7, 1'b0, 9'd0, 9'd0, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b1, 18'd7, 1'b0, 9'd0, 9'd0, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 18'd5, 1'b0, 9'd0, 9'd0, 50100, 1'b1, 1'b1, 1'b0, 1'b1);
    push_idle(50131, 1'b1, 1'b0, 1'b1);
    push_idle(65600, 1'b1, 1'b0, 1'b1);
    push_idle(65631, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b1, 1'b1, 1'b1);
    push_idle(5, 1'b0, 1'b0, 1'b1);
    run_vecs();

    // Corners 1 and 3 out of range: two ROM issues, done at N+5.
    tname = "boundary";
    push(1'b0, 1'b0, 18'd5, 1'b1, 9'd480, 9'd10, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(5480, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b1, 1'b0, 1'b1);
    push_idle(20980, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b1, 1'b1, 1'b1);
    push_idle(5, 1'b0, 1'b0, 1'b1);
    run_vecs();

    // Out-of-range retirement proceeds even while draw holds the ROM.
    tname = "boundary_draw";
    push(1'b0, 1'b0, 18'd5, 1'b1, 9'd480, 9'd10, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(5480, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b1, 18'd9, 1'b0, 9'd0, 9'd0, 9, 1'b0, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 18'd5, 1'b0, 9'd0, 9'd0, 20980, 1'b1, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b1, 1'b1, 1'b1);
    push_idle(5, 1'b0, 1'b0, 1'b1);
    run_vecs();

    tname = "far_corner_clear";
    push_probe(9'd468, 9'd468, 234468, 234499, 249968, 249999, 1'b1, 1'b0);
    run_vecs();

    tname = "far_corner_wall";
    rom_mem[249999] = 4'd0;
    push_probe(9'd468, 9'd468, 234468, 234499, 249968, 249999, 1'b0, 1'b1);
    run_vecs();

    // Start at N+2 ignored; reset at N+3 aborts with no done pulse.
    tname = "ignore_reset";
    push(1'b0, 1'b0, 18'd5, 1'b1, 9'd100, 9'd100, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(50100, 1'b1, 1'b0, 1'b1);
    push(1'b0, 1'b0, 18'd5, 1'b1, 9'd0, 9'd0, 50131, 1'b0, 1'b1, 1'b0, 1'b1);
    push(1'b1, 1'b0, 18'd5, 1'b0, 9'd0, 9'd0, 65600, 1'b0, 1'b1, 1'b0, 1'b1);
    push_idle(5, 1'b0, 1'b0, 1'b0);
    push_idle(5, 1'b0, 1'b0, 1'b0);
    push_idle(5, 1'b0, 1'b0, 1'b0);
    push_idle(5, 1'b0, 1'b0, 1'b0);
    push_probe(9'd100, 9'd100, 50100, 50131, 65600, 65631, 1'b0, 1'b1);
    run_vecs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
